// File: rtl/rv_pkg.sv
// Shared writeback-path constants: default widths and requester slot indices.
package rv_pkg;

   localparam int DEF_NUM_REQ    = 3;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_ID_WIDTH   = 2;

   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;
   localparam int REQ_CSR = 2;

   // Next index around a ring of n slots.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ  = 3,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_idx,
   output logic                any_grant
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      // Walk offsets from far to near so the nearest requester wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = ID_WIDTH'(idx);
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selection of one requester per cycle into a
// registered register-file write port, with hold (freeze) and flush (drop).
module wb_arbiter
   import rv_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           hold,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_rd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           rf_write_enable,
   output logic [ADDR_WIDTH-1:0]          rf_rd,
   output logic [DATA_WIDTH-1:0]          rf_write_data,
   output logic [ID_WIDTH-1:0]            grant_id
);

   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   pick_idx;
   logic [NUM_REQ-1:0]    pick_onehot;
   logic                  pick_any;
   logic                  block;
   logic                  transfer;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   rr_picker #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_picker (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (pick_onehot),
      .grant_idx (pick_idx),
      .any_grant (pick_any)
   );

   // No acceptance while the pipe is flushing, frozen or in reset.
   assign block     = flush | hold | ~rst_n;
   assign req_ready = block ? '0 : pick_onehot;
   assign transfer  = pick_any & ~block;

   assign sel_rd   = req_rd[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_data = req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (transfer)
         rr_ptr <= ID_WIDTH'(wrap_inc(int'(pick_idx), NUM_REQ));
   end

   // Flush beats hold; hold keeps the staged write so it repeats harmlessly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_write_enable <= 1'b0;
         rf_rd           <= '0;
         rf_write_data   <= '0;
         grant_id        <= '0;
      end else if (flush) begin
         rf_write_enable <= 1'b0;
      end else if (!hold) begin
         rf_write_enable <= transfer && (sel_rd != '0);
         if (transfer) begin
            rf_rd         <= sel_rd;
            rf_write_data <= sel_data;
            grant_id      <= pick_idx;
         end
      end
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of writeback requesters (ALU, load unit, CSR unit).
REQ-002 Parameter DATA_WIDTH, default 32: register data width.
REQ-003 Parameter ADDR_WIDTH, default 5: register address width.
REQ-004 Parameter ID_WIDTH, default 2: requester index width; it SHALL satisfy 2**ID_WIDTH >= NUM_REQ.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 flush  input  1  pipeline flush; drops the staged write and blocks grants this cycle.
REQ-008 hold  input  1  freeze; no grants, staged write retained.
REQ-009 req_valid  input  NUM_REQ  per-requester write request.
REQ-010 req_rd  input  NUM_REQ*ADDR_WIDTH  destination registers; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 req_data  input  NUM_REQ*DATA_WIDTH  write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 req_ready  output  NUM_REQ  per-requester accept; combinational.
REQ-013 rf_write_enable  output  1  register-file write strobe; registered.
REQ-014 rf_rd  output  ADDR_WIDTH  register-file destination; registered.
REQ-015 rf_write_data  output  DATA_WIDTH  register-file data; registered.
REQ-016 grant_id  output  ID_WIDTH  index of the requester behind the current rf_* outputs; registered.

Function
REQ-017 A transfer from requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-018 At most one req_ready bit SHALL be 1 in any cycle.
REQ-019 req_ready SHALL be all zero whenever flush=1, hold=1, or rst_n=0.
REQ-020 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and increments modulo NUM_REQ; the first valid requester found is granted.
REQ-021 After a transfer from requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no transfer, rr_ptr SHALL be unchanged.
REQ-022 Latency: a transfer in cycle N SHALL drive rf_rd, rf_write_data and grant_id from that request in cycle N+1.
REQ-023 In cycle N+1, rf_write_enable SHALL be 1 only if the transferred rd is non-zero.
REQ-024 An rd=0 request SHALL still be accepted and SHALL still advance rr_ptr.
REQ-025 In a cycle with no transfer, rf_write_enable SHALL be 0 in the next cycle unless hold=1.
REQ-026 While hold=1, rf_write_enable, rf_rd, rf_write_data and grant_id SHALL keep their values, so a staged write repeats (idempotent).
REQ-027 flush=1 SHALL force rf_write_enable=0 in the next cycle; flush SHALL take priority over hold.
REQ-028 Requesters SHALL keep valid, rd and data stable until accepted; the bench SHALL treat a drop of valid before acceptance as a protocol error.
REQ-029 A single requester SHALL be able to transfer every cycle when it is the only one valid (full throughput).
REQ-030 With all NUM_REQ requesters continuously valid, each SHALL be granted exactly once per NUM_REQ cycles (no starvation).

Reset
REQ-031 While rst_n=0, rr_ptr, rf_write_enable, rf_rd, rf_write_data and grant_id SHALL be 0 on the next edge; reset SHALL override flush and hold.
REQ-032 A reset asserted mid-stream SHALL discard the staged write, so no write occurs in the cycle after reset.

Structure
REQ-033 NUM_REQ, ADDR_WIDTH, DATA_WIDTH defaults and the requester index constants (REQ_ALU=0, REQ_LSU=1, REQ_CSR=2) SHALL live in a shared package, rv_pkg.
REQ-034 The round-robin pick SHALL be a sub-module rr_picker (inputs: request vector, pointer; outputs: one-hot grant, grant index).
REQ-035 The wb_arbiter outputs SHALL connect directly to the register file write port (write_enable, rd, write_data).

Verification
REQ-036 Reset, then only req_valid=3'b001 with rd=5, data=0xDEADBEEF -> req_ready=001 in the same cycle; next cycle rf_write_enable=1, rf_rd=5, rf_write_data=0xDEADBEEF, grant_id=0.
REQ-037 All three valid for 6 cycles, starting from rr_ptr=0 -> grant order 0,1,2,0,1,2; each requester is granted twice.
REQ-038 Requester 1 valid with rd=0, data=0x1234 -> accepted; next cycle rf_write_enable=0; rr_ptr becomes 2.
REQ-039 Transfer of rd=7 in cycle N, then hold=1 for cycles N+1..N+3 -> rf_write_enable=1, rf_rd=7 held through N+3 and req_ready=000 throughout.
REQ-040 Transfer in cycle N, then flush=1 and hold=1 in cycle N+1 -> rf_write_enable=0 in N+2 and no grant in N+1.
REQ-041 rst_n=0 in the cycle after a transfer -> rf_write_enable=0 and grant_id=0 in the next cycle; the register file is not written.
